// File: rtl/sobel_edge_stream_pkg.sv
// sobel_pkg: pixel, gradient and magnitude types for the default 8-bit pixel,
// plus the saturating clamp used to fit a Sobel magnitude back into a pixel.
package sobel_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0]        pix_t;
    typedef logic signed [PIX_W_DEF+3:0] grad_t;
    typedef logic [PIX_W_DEF+2:0]        mag_t;

    function automatic logic [31:0] sat_u(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (v > m) ? m : v;
    endfunction

endpackage

// File: rtl/sobel_edge_stream_line_buffer.sv
// line_buffer: one image row of pixels; combinational read of the old entry and
// write of the new one at the same index on each enabled cycle.
module line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int W     = PIX_W_DEF,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [AW-1:0] idx,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    assign rdata = mem_q[idx];

    always_comb begin
        mem_d = mem_q;
        if (en) mem_d[idx] = wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mem_q <= '{default: '0};
        else       mem_q <= mem_d;
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: raster-order 3x3 Sobel edge detector with two row buffers,
// saturating or thresholded output, and centre coordinates of every result.
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter  int PIX_W = PIX_W_DEF,
    parameter  int IMG_W = 10,
    parameter  int IMG_H = 10,
    localparam int CW    = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pixel_input,
    input  logic             pixel_valid,
    input  logic             pixel_sof,
    input  logic             thresh_en,
    input  logic [PIX_W-1:0] threshold,
    output logic [PIX_W-1:0] edge_output,
    output logic             edge_output_valid,
    output logic [CW-1:0]    edge_row,
    output logic [CW-1:0]    edge_col,
    output logic             frame_done
);

    localparam int GW = PIX_W + 4;
    localparam int MW = PIX_W + 3;

    logic [CW-1:0]        row_q, row_d, col_q, col_d, cur_row, cur_col;
    logic [CW-1:0]        erow_q, erow_d, ecol_q, ecol_d;
    logic [PIX_W-1:0]     win_q [3][3];
    logic [PIX_W-1:0]     win_d [3][3];
    logic [PIX_W-1:0]     lb0_rd, lb1_rd, edge_q, edge_d;
    logic                 valid_q, valid_d, done_q, done_d;
    logic                 last_col, last_row, complete;
    logic signed [GW-1:0] sum_l, sum_r, sum_t, sum_b, gx, gy;
    logic [MW-1:0]        mag;

    // lb0 holds row r-1, lb1 holds row r-2; lb1 is fed by what lb0 is evicting
    line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb0 (
        .clk(clk), .reset(reset), .en(pixel_valid), .idx(cur_col),
        .wdata(pixel_input), .rdata(lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_lb1 (
        .clk(clk), .reset(reset), .en(pixel_valid), .idx(cur_col),
        .wdata(lb0_rd), .rdata(lb1_rd)
    );

    always_comb begin
        cur_row  = pixel_sof ? '0 : row_q;
        cur_col  = pixel_sof ? '0 : col_q;
        last_col = cur_col == CW'(IMG_W - 1);
        last_row = cur_row == CW'(IMG_H - 1);
        col_d    = !pixel_valid ? col_q : last_col ? '0 : cur_col + 1'b1;
        row_d    = !pixel_valid ? row_q : !last_col ? cur_row : last_row ? '0 : cur_row + 1'b1;
        win_d    = win_q;
        if (pixel_valid) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = pixel_input;
        end
        // gradients are taken on the window as it will look after this accept
        sum_l    = GW'(win_d[0][0]) + GW'({win_d[1][0], 1'b0}) + GW'(win_d[2][0]);
        sum_r    = GW'(win_d[0][2]) + GW'({win_d[1][2], 1'b0}) + GW'(win_d[2][2]);
        sum_t    = GW'(win_d[0][0]) + GW'({win_d[0][1], 1'b0}) + GW'(win_d[0][2]);
        sum_b    = GW'(win_d[2][0]) + GW'({win_d[2][1], 1'b0}) + GW'(win_d[2][2]);
        gx       = sum_r - sum_l;
        gy       = sum_b - sum_t;
        mag      = MW'(gx[GW-1] ? -gx : gx) + MW'(gy[GW-1] ? -gy : gy);
        complete = pixel_valid && cur_row >= CW'(2) && cur_col >= CW'(2);
        edge_d   = !complete ? edge_q
                 : thresh_en ? {PIX_W{mag >= MW'(threshold)}}
                 : PIX_W'(sat_u(32'(mag), PIX_W));
        valid_d  = complete;
        erow_d   = complete ? cur_row - 1'b1 : erow_q;
        ecol_d   = complete ? cur_col - 1'b1 : ecol_q;
        done_d   = pixel_valid && last_row && last_col;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= '{default: '0};
            edge_q  <= '0;
            valid_q <= 1'b0;
            erow_q  <= '0;
            ecol_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
            edge_q  <= edge_d;
            valid_q <= valid_d;
            erow_q  <= erow_d;
            ecol_q  <= ecol_d;
            done_q  <= done_d;
        end
    end

    assign edge_output       = edge_q;
    assign edge_output_valid = valid_q;
    assign edge_row          = erow_q;
    assign edge_col          = ecol_q;
    assign frame_done        = done_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: drives raster frames with gaps, resyncs and resets, and
// compares every cycle against an image-array Sobel model.
module tb_sobel_edge_stream;
    import sobel_pkg::*;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    pix_t          pixel_input = '0;
    logic          pixel_valid = 1'b0;
    logic          pixel_sof = 1'b0;
    logic          thresh_en = 1'b0;
    pix_t          threshold = '0;
    pix_t          edge_output;
    logic          edge_output_valid;
    logic [CW-1:0] edge_row;
    logic [CW-1:0] edge_col;
    logic          frame_done;

    int n_vec = 0;
    int n_err = 0;
    int res_cnt = 0;
    int done_cnt = 0;
    int mr = 0;
    int mc = 0;
    int img [H][W];
    logic exp_vld, exp_done;
    int exp_edge, exp_row, exp_col;

    sobel_edge_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .pixel_input(pixel_input), .pixel_valid(pixel_valid),
        .pixel_sof(pixel_sof), .thresh_en(thresh_en), .threshold(threshold),
        .edge_output(edge_output), .edge_output_valid(edge_output_valid),
        .edge_row(edge_row), .edge_col(edge_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_edge(input int r, input int c, input logic te, input int th);
        int gx, gy, mag, k;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            k = (i == 1) ? 2 : 1;
            gx += k * (img[r-2+i][c] - img[r-2+i][c-2]);
            gy += k * (img[r][c-2+i] - img[r-2][c-2+i]);
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return te ? (mag >= th ? 255 : 0) : (mag > 255 ? 255 : mag);
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, int'(edge_output_valid), 0);
        check({tag, "_edge"}, int'(edge_output), 0);
        check({tag, "_row"}, int'(edge_row), 0);
        check({tag, "_col"}, int'(edge_col), 0);
        check({tag, "_done"}, int'(frame_done), 0);
    endtask

    task automatic step(input logic v, input int p, input logic s);
        pixel_valid = v;
        pixel_input = pix_t'(p);
        pixel_sof   = s;
        exp_vld  = 1'b0;
        exp_done = 1'b0;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            exp_vld = mr >= 2 && mc >= 2;
            if (exp_vld) begin
                exp_edge = ref_edge(mr, mc, thresh_en, int'(threshold));
                exp_row  = mr - 1;
                exp_col  = mc - 1;
            end
            exp_done = mr == H - 1 && mc == W - 1;
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        check("valid", int'(edge_output_valid), int'(exp_vld));
        check("frame_done", int'(frame_done), int'(exp_done));
        if (exp_vld) begin
            check("edge", int'(edge_output), exp_edge);
            check("row", int'(edge_row), exp_row);
            check("col", int'(edge_col), exp_col);
        end
        res_cnt  += int'(edge_output_valid);
        done_cnt += int'(frame_done);
    endtask

    function automatic int pix_of(input int kind, input int r, input int c);
        return kind == 0 ? (r >= 5 ? 255 : 0)
             : kind == 1 ? 10 * c
             : kind == 2 ? 128
             : int'($urandom_range(255));
    endfunction

    task automatic idle();
        step(1'b0, int'($urandom_range(255)), 1'($urandom_range(1)));
    endtask

    // kind: 0 step, 1 column ramp, 2 uniform 0x80, 3 random; gap: 0 none, 1 alternate, 2 random
    task automatic frame(input int kind, input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (kind == 3) begin
                    thresh_en = 1'($urandom_range(1));
                    threshold = pix_t'($urandom_range(255));
                end
                if (gap == 1) idle();
                if (gap == 2) repeat ($urandom_range(2)) idle();
                step(1'b1, pix_of(kind, r, c), r == 0 && c == 0);
            end
        end
    endtask

    task automatic mid_reset();
        reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid");
        mr = 0;
        mc = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        res_cnt = 0; done_cnt = 0;
        frame(0, 0);
        check("step_results", res_cnt, 64);
        check("step_frame_done", done_cnt, 1);

        thresh_en = 1'b0;
        frame(1, 0);
        thresh_en = 1'b1; threshold = 8'h50;
        frame(1, 0);
        threshold = 8'h51;
        frame(1, 0);
        thresh_en = 1'b0;

        res_cnt = 0;
        frame(2, 1);
        check("gap_results", res_cnt, 64);

        frame(0, 0);
        res_cnt = 0;
        frame(2, 0);
        check("b2b_results", res_cnt, 64);

        for (int i = 0; i < 37; i++) step(1'b1, pix_of(0, i / W, i % W), i == 0);
        mid_reset();
        res_cnt = 0; done_cnt = 0;
        frame(0, 0);
        check("post_reset_results", res_cnt, 64);
        check("post_reset_done", done_cnt, 1);

        for (int i = 0; i < 34; i++) step(1'b1, int'($urandom_range(255)), i == 0);
        res_cnt = 0;
        frame(3, 2);
        check("resync_results", res_cnt, 64);

        res_cnt = 0; done_cnt = 0;
        repeat (3) frame(3, 2);
        check("random_results", res_cnt, 192);
        check("random_done", done_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
